// File: rtl/psum_accum_quant.sv
// Accumulates a programmed number of per-lane partial-sum vectors, adds bias, optionally applies ReLU,
// then rounds, shifts and saturates each lane to int8 and holds the result until the output handshake.
module psum_accum_quant #(
  parameter int LANES = 8,
  parameter int ACC_W = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [7:0]             cfg_num_tiles,
  input  logic [4:0]             cfg_shift,
  input  logic                   cfg_relu,
  input  logic [LANES-1:0][31:0] bias,
  input  logic                   in_valid,
  input  logic [LANES-1:0][31:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0][7:0]  out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err_drop
);

  // Two guard bits: the bias add and the rounding constant can each carry once.
  localparam int V_W = ACC_W + 2;
  localparam logic signed [V_W-1:0] SAT_MAX = 127;
  localparam logic signed [V_W-1:0] SAT_MIN = -128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_QUANT,
    S_OUT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_start;
  logic                      w_accept;

  logic [7:0]                r_num_tiles;
  logic [7:0]                r_tile_cnt;
  logic [4:0]                r_shift;
  logic                      r_relu;
  logic [LANES-1:0][31:0]    r_bias;
  logic signed [ACC_W-1:0]   r_acc [LANES];
  logic [LANES-1:0][7:0]     r_out_data;
  logic                      r_done;
  logic                      r_err_drop;

  logic signed [V_W-1:0]     w_v;
  logic signed [V_W-1:0]     w_rnd;
  logic [LANES-1:0][7:0]     w_quant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          w_accept = 1'b1;
          if (r_tile_cnt == r_num_tiles - 8'd1) begin
            w_state_nxt = S_QUANT;
          end
        end
      end
      S_QUANT: begin
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-lane requantization of the finished accumulators.
  always_comb begin
    w_v     = '0;
    w_rnd   = '0;
    w_quant = '0;
    for (int i = 0; i < LANES; i++) begin
      w_v = {{2{r_acc[i][ACC_W-1]}}, r_acc[i]} + {{(V_W-32){r_bias[i][31]}}, r_bias[i]};
      if (r_relu && w_v[V_W-1]) begin
        w_v = '0;
      end
      if (r_shift != 5'd0) begin
        w_rnd = '0;
        w_rnd = w_rnd + (V_W'(1) << (r_shift - 5'd1));
        w_v   = (w_v + w_rnd) >>> r_shift;
      end
      if (w_v > SAT_MAX) begin
        w_quant[i] = 8'h7F;
      end else if (w_v < SAT_MIN) begin
        w_quant[i] = 8'h80;
      end else begin
        w_quant[i] = w_v[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_tiles <= '0;
      r_tile_cnt  <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_bias      <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_err_drop  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_done <= (r_state == S_OUT) && out_ready;

      // A beat arriving with the start pulse is still dropped, so the flag restarts from in_valid.
      if (w_start) begin
        r_num_tiles <= (cfg_num_tiles == 8'd0) ? 8'd1 : cfg_num_tiles;
        r_shift     <= cfg_shift;
        r_relu      <= cfg_relu;
        r_bias      <= bias;
        r_tile_cnt  <= '0;
        r_err_drop  <= in_valid;
        for (int i = 0; i < LANES; i++) begin
          r_acc[i] <= '0;
        end
      end else if (in_valid && (r_state != S_ACCUM)) begin
        r_err_drop <= 1'b1;
      end

      if (w_accept) begin
        r_tile_cnt <= r_tile_cnt + 8'd1;
        for (int i = 0; i < LANES; i++) begin
          r_acc[i] <= r_acc[i] + {{(ACC_W-32){in_data[i][31]}}, in_data[i]};
        end
      end

      if (r_state == S_QUANT) begin
        r_out_data <= w_quant;
      end
    end
  end

  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign done      = r_done;
  assign err_drop  = r_err_drop;

endmodule

// File: tb/tb_psum_accum_quant.sv
// Directed vector bench for psum_accum_quant: table of hand-computed jobs plus handshake/reset corner sequences.
module tb_psum_accum_quant;
  localparam int LANES = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_start;
  logic [7:0]             cfg_num_tiles;
  logic [4:0]             cfg_shift;
  logic                   cfg_relu;
  logic [LANES-1:0][31:0] bias;
  logic                   in_valid;
  logic [LANES-1:0][31:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0][7:0]  out_data;
  logic                   busy;
  logic                   done;
  logic                   err_drop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  psum_accum_quant #(.LANES(LANES), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_tiles(cfg_num_tiles),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .bias(bias), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err_drop(err_drop)
  );

  // Lane 0 gets d*, lane 1 gets -d*, lanes 2..7 get zero data and zero bias.
  typedef struct {
    int n; int sh; int relu; int b0; int b1;
    int d0; int d1; int d2; int e0; int e1;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nonzero_lanes(input int from);
    int cnt = 0;
    for (int l = from; l < LANES; l++) begin
      if (out_data[l] != 8'd0) cnt++;
    end
    return cnt;
  endfunction

  task automatic start_job(input int n, input int sh, input int relu, input int b0, input int b1);
    logic [31:0] t;
    cfg_start     = 1'b1;
    t             = n;
    cfg_num_tiles = t[7:0];
    t             = sh;
    cfg_shift     = t[4:0];
    cfg_relu      = (relu != 0);
    bias          = '0;
    bias[0]       = b0;
    bias[1]       = b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic beat(input int d0, input int d1);
    in_valid   = 1'b1;
    in_data    = '0;
    in_data[0] = d0;
    in_data[1] = d1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    vecs[0] = '{3, 0,  0, 0,    0,  10,         20,         30, 60,  -60};
    vecs[1] = '{1, 4,  0, 8,    8,  256,        0,          0,  17,  -15};
    vecs[2] = '{1, 0,  0, 0,    0,  5000,       0,          0,  127, -128};
    vecs[3] = '{1, 2,  1, 0,    0,  -40,        0,          0,  0,   10};
    vecs[4] = '{1, 2,  0, 0,    0,  -40,        0,          0,  -10, 10};
    vecs[5] = '{0, 1,  0, 0,    0,  3,          0,          0,  2,   -1};
    vecs[6] = '{2, 3,  0, -100, 0,  50,         60,         0,  1,   -14};
    vecs[7] = '{1, 0,  0, 0,    -1, 127,        0,          0,  127, -128};
    vecs[8] = '{2, 31, 0, 0,    0,  2147483647, 2147483647, 0,  2,   -2};

    rst = 1'b1; cfg_start = 1'b0; cfg_num_tiles = '0; cfg_shift = '0; cfg_relu = 1'b0;
    bias = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_drop", int'(err_drop), 0);
    chk("rst_out_data", nonzero_lanes(0), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      int nb;
      int d;
      nb = (vecs[i].n == 0) ? 1 : vecs[i].n;
      start_job(vecs[i].n, vecs[i].sh, vecs[i].relu, vecs[i].b0, vecs[i].b1);
      for (int k = 0; k < nb; k++) begin
        d = (k == 0) ? vecs[i].d0 : (k == 1) ? vecs[i].d1 : vecs[i].d2;
        beat(d, -d);
      end
      chk($sformatf("v%0d_quant_not_valid", i), int'(out_valid), 0);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), 1);
      chk($sformatf("v%0d_lane0", i), int'($signed(out_data[0])), vecs[i].e0);
      chk($sformatf("v%0d_lane1", i), int'($signed(out_data[1])), vecs[i].e1);
      chk($sformatf("v%0d_other_lanes", i), nonzero_lanes(2), 0);
      @(negedge clk);
      chk($sformatf("v%0d_done", i), int'(done), 1);
      chk($sformatf("v%0d_idle", i), int'(busy), 0);
      chk($sformatf("v%0d_err_drop", i), int'(err_drop), 0);
    end

    // Back-pressure with a stray beat and an ignored cfg_start while holding the result.
    out_ready = 1'b0;
    start_job(1, 0, 0, 0, 0);
    beat(7, -7);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_out_valid", c), int'(out_valid), 1);
      chk($sformatf("bp%0d_busy", c), int'(busy), 1);
      chk($sformatf("bp%0d_hold", c), int'($signed(out_data[0])), 7);
      if (c == 1) begin
        in_valid = 1'b1; in_data[0] = 100; cfg_start = 1'b1; cfg_shift = 5'd3;
      end
      @(negedge clk);
      in_valid = 1'b0; in_data = '0; cfg_start = 1'b0;
    end
    chk("bp_err_set", int'(err_drop), 1);
    chk("bp_hold_final", int'($signed(out_data[0])), 7);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", int'(done), 1);
    chk("bp_err_sticky", int'(err_drop), 1);
    // Start in the same cycle as done.
    start_job(1, 0, 0, 0, 0);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_err_cleared", int'(err_drop), 0);
    chk("b2b_done_pulse", int'(done), 0);
    beat(9, -9);
    @(negedge clk);
    chk("b2b_lane0", int'($signed(out_data[0])), 9);
    @(negedge clk);

    // Start together with a beat: job begins, beat dropped.
    cfg_start = 1'b1; cfg_num_tiles = 8'd1; cfg_shift = 5'd0; cfg_relu = 1'b0; bias = '0;
    in_valid = 1'b1; in_data[0] = 99;
    @(negedge clk);
    cfg_start = 1'b0; in_valid = 1'b0; in_data = '0;
    chk("sv_err", int'(err_drop), 1);
    chk("sv_busy", int'(busy), 1);
    beat(4, -4);
    @(negedge clk);
    chk("sv_lane0", int'($signed(out_data[0])), 4);
    chk("sv_lane1", int'($signed(out_data[1])), -4);
    @(negedge clk);

    // Stray beat in IDLE, then reset clears the sticky flag.
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_stray_err", int'(err_drop), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clears_err", int'(err_drop), 0);

    // Reset after the 2nd of 4 beats, overriding start and valid in the same cycle.
    start_job(4, 0, 0, 0, 0);
    beat(1, -1);
    beat(2, -2);
    rst = 1'b1; in_valid = 1'b1; cfg_start = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; cfg_start = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_data", nonzero_lanes(0), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_err", int'(err_drop), 0);
    @(negedge clk);
    chk("mid_rst_stays_idle", int'(busy), 0);
    start_job(2, 0, 0, 0, 0);
    beat(5, -5);
    beat(6, -6);
    @(negedge clk);
    chk("fresh_valid", int'(out_valid), 1);
    chk("fresh_lane0", int'($signed(out_data[0])), 11);
    chk("fresh_lane1", int'($signed(out_data[1])), -11);
    @(negedge clk);
    chk("fresh_done", int'(done), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
